can_mac_rx_frame_parser: RTL and testbench

- Downstream consumer of the RX bit destuffer. Accepts destuffed bits with a valid/ready handshake and parses CAN 2.0A base-format frames: SOF, 11-bit ID, RTR, IDE, r0, DLC, data, CRC-15, delimiters, ACK, EOF.
- Drives the destuffer's `destuffing_enable` and checks CRC and form.
- Presents a completed frame to the MAC RX buffer with a one-cycle strobe.

---
 rtl/can_mac_rx_frame_parser.sv | 222 ++++++++++++++++++++++
 tb/tb_can_mac_rx_frame_parser.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/can_mac_rx_frame_parser.sv
// CAN 2.0A base-frame receive parser: consumes destuffed bits, tracks frame fields,
// checks CRC-15 and fixed-form bits, and strobes completed frames to the RX buffer.
module can_mac_rx_frame_parser #(
  parameter int INTEGRATION_BITS  = 11,
  parameter int INTERMISSION_BITS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        can_clk_en,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic        stuff_error,
  output logic        ready,
  output logic        destuffing_enable,
  output logic [10:0] rx_id,
  output logic        rx_rtr,
  output logic [3:0]  rx_dlc,
  output logic [63:0] rx_data,
  output logic        ack_req,
  output logic        frame_valid,
  output logic        crc_error,
  output logic        form_error,
  output logic        stuff_error_out,
  output logic        bus_idle
);

  typedef enum logic [3:0] {
    S_INTEGRATE, S_IDLE, S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA,
    S_CRC, S_CRC_DELIM, S_ACK_SLOT, S_ACK_DELIM, S_EOF, S_INTERMISSION
  } state_t;

  state_t      state;
  logic [6:0]  cnt;
  logic [6:0]  data_bits;
  logic [14:0] crc;
  logic [14:0] rx_crc;
  logic        take;
  logic [3:0]  dlc_full;
  logic [6:0]  payload_bits;

  function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
    crc_step = {c[13:0], 1'b0} ^ ((b ^ c[14]) ? 15'h4599 : 15'h0000);
  endfunction

  assign take = can_clk_en & bit_valid & ready;

  // Payload length is decided on the last DLC bit, before rx_dlc has been updated.
  always_comb begin
    dlc_full = {rx_dlc[2:0], bit_in};
    if (rx_rtr)
      payload_bits = 7'd0;
    else if (dlc_full > 4'd8)
      payload_bits = 7'd64;
    else
      payload_bits = {dlc_full, 3'b000};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_INTEGRATE;
      cnt               <= 7'd0;
      data_bits         <= 7'd0;
      crc               <= 15'd0;
      rx_crc            <= 15'd0;
      rx_id             <= 11'd0;
      rx_rtr            <= 1'b0;
      rx_dlc            <= 4'd0;
      rx_data           <= 64'd0;
      ready             <= 1'b0;
      destuffing_enable <= 1'b0;
      ack_req           <= 1'b0;
      frame_valid       <= 1'b0;
      crc_error         <= 1'b0;
      form_error        <= 1'b0;
      stuff_error_out   <= 1'b0;
      bus_idle          <= 1'b0;
    end else begin
      ready           <= 1'b1;
      frame_valid     <= 1'b0;
      crc_error       <= 1'b0;
      form_error      <= 1'b0;
      stuff_error_out <= 1'b0;
      if (stuff_error && destuffing_enable) begin
        stuff_error_out   <= 1'b1;
        destuffing_enable <= 1'b0;
        state             <= S_INTEGRATE;
        cnt               <= 7'd0;
      end else if (take) begin
        case (state)
          S_INTEGRATE: begin
            if (!bit_in)
              cnt <= 7'd0;
            else if (cnt == 7'(INTEGRATION_BITS - 1)) begin
              cnt      <= 7'd0;
              state    <= S_IDLE;
              bus_idle <= 1'b1;
            end else
              cnt <= cnt + 7'd1;
          end
          // A dominant bit in intermission is a SOF, exactly as in IDLE.
          S_IDLE, S_INTERMISSION: begin
            if (!bit_in) begin
              destuffing_enable <= 1'b1;
              crc               <= crc_step(15'd0, 1'b0);
              rx_data           <= 64'd0;
              cnt               <= 7'd0;
              bus_idle          <= 1'b0;
              state             <= S_ID;
            end else if (state == S_INTERMISSION) begin
              if (cnt == 7'(INTERMISSION_BITS - 1)) begin
                cnt      <= 7'd0;
                state    <= S_IDLE;
                bus_idle <= 1'b1;
              end else
                cnt <= cnt + 7'd1;
            end
          end
          S_ID: begin
            rx_id <= {rx_id[9:0], bit_in};
            crc   <= crc_step(crc, bit_in);
            if (cnt == 7'd10) begin
              cnt   <= 7'd0;
              state <= S_RTR;
            end else
              cnt <= cnt + 7'd1;
          end
          S_RTR: begin
            rx_rtr <= bit_in;
            crc    <= crc_step(crc, bit_in);
            state  <= S_IDE;
          end
          S_IDE: begin
            crc <= crc_step(crc, bit_in);
            if (bit_in) begin
              form_error        <= 1'b1;
              destuffing_enable <= 1'b0;
              state             <= S_INTEGRATE;
              cnt               <= 7'd0;
            end else
              state <= S_R0;
          end
          S_R0: begin
            crc   <= crc_step(crc, bit_in);
            state <= S_DLC;
          end
          S_DLC: begin
            rx_dlc <= dlc_full;
            crc    <= crc_step(crc, bit_in);
            if (cnt == 7'd3) begin
              cnt       <= 7'd0;
              data_bits <= payload_bits;
              state     <= (payload_bits == 7'd0) ? S_CRC : S_DATA;
            end else
              cnt <= cnt + 7'd1;
          end
          S_DATA: begin
            rx_data[~cnt[5:0]] <= bit_in;
            crc                <= crc_step(crc, bit_in);
            if (cnt == data_bits - 7'd1) begin
              cnt   <= 7'd0;
              state <= S_CRC;
            end else
              cnt <= cnt + 7'd1;
          end
          S_CRC: begin
            rx_crc <= {rx_crc[13:0], bit_in};
            if (cnt == 7'd14) begin
              cnt               <= 7'd0;
              destuffing_enable <= 1'b0;
              state             <= S_CRC_DELIM;
            end else
              cnt <= cnt + 7'd1;
          end
          S_CRC_DELIM: begin
            if (!bit_in) begin
              form_error <= 1'b1;
              state      <= S_INTEGRATE;
            end else if (rx_crc != crc) begin
              crc_error <= 1'b1;
              state     <= S_INTEGRATE;
            end else begin
              ack_req <= 1'b1;
              state   <= S_ACK_SLOT;
            end
          end
          S_ACK_SLOT: begin
            ack_req <= 1'b0;
            state   <= S_ACK_DELIM;
          end
          S_ACK_DELIM: begin
            if (!bit_in) begin
              form_error <= 1'b1;
              state      <= S_INTEGRATE;
            end else
              state <= S_EOF;
          end
          // The strobe fires on the 6th EOF bit; the 7th must still be recessive.
          S_EOF: begin
            if (!bit_in) begin
              form_error <= 1'b1;
              cnt        <= 7'd0;
              state      <= S_INTEGRATE;
            end else begin
              if (cnt == 7'd5)
                frame_valid <= 1'b1;
              if (cnt == 7'd6) begin
                cnt   <= 7'd0;
                state <= S_INTERMISSION;
              end else
                cnt <= cnt + 7'd1;
            end
          end
          default: begin
            state <= S_INTEGRATE;
            cnt   <= 7'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_can_mac_rx_frame_parser.sv
// Directed bench for can_mac_rx_frame_parser: frames are built field by field and the
// expected per-bit outputs are derived from field positions and a long-division CRC model.
module tb_can_mac_rx_frame_parser;

  localparam int INTEG = 11;
  localparam int INTERM = 3;

  logic        clk, reset, can_clk_en, bit_in, bit_valid, stuff_error;
  logic        ready, destuffing_enable, rx_rtr, ack_req, frame_valid;
  logic        crc_error, form_error, stuff_error_out, bus_idle;
  logic [10:0] rx_id;
  logic [3:0]  rx_dlc;
  logic [63:0] rx_data;

  can_mac_rx_frame_parser #(.INTEGRATION_BITS(INTEG), .INTERMISSION_BITS(INTERM)) dut (
    .clk(clk), .reset(reset), .can_clk_en(can_clk_en), .bit_in(bit_in),
    .bit_valid(bit_valid), .stuff_error(stuff_error), .ready(ready),
    .destuffing_enable(destuffing_enable), .rx_id(rx_id), .rx_rtr(rx_rtr),
    .rx_dlc(rx_dlc), .rx_data(rx_data), .ack_req(ack_req), .frame_valid(frame_valid),
    .crc_error(crc_error), .form_error(form_error), .stuff_error_out(stuff_error_out),
    .bus_idle(bus_idle)
  );

  always #5 clk = ~clk;

  int n_checks, n_fail;
  logic chk_on;
  logic fb [0:255];

  // Staged (nx_) and live (exp_) expectations; rx mode 0 = unchecked, 1 = data cleared, 2 = all rx_*.
  logic exp_ready, exp_de, exp_ack, exp_fv, exp_crc, exp_form, exp_stuff, exp_idle, exp_rtr;
  logic nx_de, nx_ack, nx_fv, nx_crc, nx_form, nx_stuff, nx_idle, nx_rtr;
  int exp_mode, nx_mode;
  logic [10:0] exp_id, nx_id;
  logic [3:0]  exp_dlc, nx_dlc;
  logic [63:0] exp_data, nx_data;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // CRC as the remainder of msg(x)*x^15 divided by x^15+0x4599, by long division.
  function automatic logic [14:0] crcOf(input int len);
    logic a [0:143];
    logic [15:0] g;
    logic [14:0] r;
    g = 16'hC599;
    for (int i = 0; i < 144; i++) a[i] = (i < len) ? fb[i] : 1'b0;
    for (int i = 0; i < len; i++)
      if (a[i]) for (int j = 0; j < 16; j++) a[i+j] = a[i+j] ^ g[15-j];
    for (int i = 0; i < 15; i++) r[14-i] = a[len+i];
    return r;
  endfunction

  function automatic int eofStart(input logic rtr, input logic [3:0] dlc);
    int n;
    n = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    return 37 + 8 * n;
  endfunction

  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      checkOutput("ready", 64'(ready), 64'(exp_ready));
      checkOutput("bus_idle", 64'(bus_idle), 64'(exp_idle));
      checkOutput("destuffing_enable", 64'(destuffing_enable), 64'(exp_de));
      checkOutput("ack_req", 64'(ack_req), 64'(exp_ack));
      checkOutput("frame_valid", 64'(frame_valid), 64'(exp_fv));
      checkOutput("crc_error", 64'(crc_error), 64'(exp_crc));
      checkOutput("form_error", 64'(form_error), 64'(exp_form));
      checkOutput("stuff_error_out", 64'(stuff_error_out), 64'(exp_stuff));
      if (exp_mode == 1) checkOutput("rx_data_sof", rx_data, 64'd0);
      if (exp_mode == 2) begin
        checkOutput("rx_id", 64'(rx_id), 64'(exp_id));
        checkOutput("rx_rtr", 64'(rx_rtr), 64'(exp_rtr));
        checkOutput("rx_dlc", 64'(rx_dlc), 64'(exp_dlc));
        checkOutput("rx_data", rx_data, exp_data);
      end
    end
  end

  task automatic applyStimulus(input logic b, input logic v, input logic se);
    @(negedge clk);
    bit_in = b; bit_valid = v; stuff_error = se; can_clk_en = 1'b1;
    exp_de = nx_de; exp_ack = nx_ack; exp_fv = nx_fv; exp_crc = nx_crc;
    exp_form = nx_form; exp_stuff = nx_stuff; exp_idle = nx_idle; exp_mode = nx_mode;
    exp_id = nx_id; exp_rtr = nx_rtr; exp_dlc = nx_dlc; exp_data = nx_data;
    @(negedge clk);
    can_clk_en = 1'b0; bit_valid = 1'b1; bit_in = 1'b0; stuff_error = 1'b0;
    exp_fv = 1'b0; exp_crc = 1'b0; exp_form = 1'b0; exp_stuff = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1; can_clk_en = 1'b0; stuff_error = 1'b0;
    nx_de = 0; nx_ack = 0; nx_fv = 0; nx_crc = 0; nx_form = 0; nx_stuff = 0; nx_idle = 0;
    nx_mode = 2; nx_id = '0; nx_rtr = 0; nx_dlc = '0; nx_data = '0;
    exp_de = 0; exp_ack = 0; exp_fv = 0; exp_crc = 0; exp_form = 0; exp_stuff = 0;
    exp_idle = 0; exp_mode = 2; exp_id = '0; exp_rtr = 0; exp_dlc = '0; exp_data = '0;
    exp_ready = 1'b0; chk_on = 1'b1;
    @(negedge clk);
    reset = 1'b0; exp_ready = 1'b1;
  endtask

  // Bus becomes idle once INTEG consecutive recessive bits have been seen.
  task automatic integrate(input int nBits, input int domPos);
    int run;
    logic b;
    run = 0;
    for (int k = 0; k < nBits; k++) begin
      b = (k == domPos) ? 1'b0 : 1'b1;
      run = b ? run + 1 : 0;
      nx_de = 0; nx_ack = 0; nx_fv = 0; nx_crc = 0; nx_form = 0; nx_stuff = 0;
      nx_idle = (run >= INTEG);
      applyStimulus(b, 1'b1, 1'b0);
    end
  endtask

  task automatic runFrame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                          input logic [63:0] data, input logic [14:0] crcFlip,
                          input int formIdx, input int stuffIdx, input int gapIdx, input int resetIdx);
    int n, p, lastCrc, delim, eof0, lastEof;
    logic [14:0] crc;
    logic crcOk, se, stop;
    n = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    fb[0] = 1'b0; p = 1;
    for (int i = 10; i >= 0; i--) begin fb[p] = id[i]; p++; end
    fb[p] = rtr; p++; fb[p] = 1'b0; p++; fb[p] = 1'b0; p++;
    for (int i = 3; i >= 0; i--) begin fb[p] = dlc[i]; p++; end
    for (int i = 0; i < 8 * n; i++) begin fb[p] = data[63-i]; p++; end
    crc = crcOf(p) ^ crcFlip;
    for (int i = 14; i >= 0; i--) begin fb[p] = crc[i]; p++; end
    lastCrc = p - 1; delim = p; eof0 = p + 3; lastEof = eof0 + 6;
    fb[p] = 1'b1; fb[p+1] = 1'b0; fb[p+2] = 1'b1;
    for (int i = 0; i < 7 + INTERM; i++) fb[eof0+i] = 1'b1;
    if (formIdx >= 0) fb[formIdx] = 1'b0;
    crcOk = (crcFlip == 15'd0);
    nx_id = id; nx_rtr = rtr; nx_dlc = dlc;
    nx_data = (n == 0) ? 64'd0 : (data & (64'hFFFF_FFFF_FFFF_FFFF << (64 - 8 * n)));
    stop = 1'b0;
    for (int k = 0; k <= lastEof + INTERM && !stop; k++) begin
      if (k == gapIdx) applyStimulus(1'b0, 1'b0, 1'b0);
      if (k == resetIdx) begin
        doReset();
        stop = 1'b1;
      end else begin
        nx_de = (k < lastCrc); nx_ack = (k == delim) && crcOk; nx_fv = (k == eof0 + 5);
        nx_idle = (k == lastEof + INTERM);
        nx_crc = 0; nx_form = 0; nx_stuff = 0; se = 1'b0;
        nx_mode = (k == 0) ? 1 : ((k >= eof0 + 5) ? 2 : 0);
        if (k == stuffIdx) begin
          se = 1'b1;
          if (k >= 1 && k <= lastCrc) begin
            nx_stuff = 1; nx_de = 0; nx_mode = 0; stop = 1'b1;
          end
        end else if (k == formIdx) begin
          nx_form = 1; nx_de = 0; nx_mode = 0; stop = 1'b1;
        end else if (k == delim && !crcOk) begin
          nx_crc = 1; stop = 1'b1;
        end
        applyStimulus(fb[k], 1'b1, se);
      end
    end
  endtask

  initial begin
    clk = 0; reset = 1; can_clk_en = 0; bit_in = 1; bit_valid = 0; stuff_error = 0;
    chk_on = 0; n_checks = 0; n_fail = 0; exp_ready = 0;
    fb[0] = 1'b1;
    checkOutput("crc_model_x15", 64'(crcOf(1)), 64'h4599);
    fb[1] = 1'b0;
    checkOutput("crc_model_x16", 64'(crcOf(2)), 64'h4EAB);

    doReset();
    integrate(11, -1);
    doReset();
    integrate(16, 4);

    runFrame(11'h123, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 15'd0, -1,
             eofStart(1'b0, 4'd2) - 2, -1, -1);
    checkOutput("frameA_id_literal", 64'(rx_id), 64'h123);
    checkOutput("frameA_data_literal", rx_data, 64'hA55A_0000_0000_0000);

    runFrame(11'h123, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 15'h0008, -1, -1, -1, -1);
    integrate(11, -1);

    runFrame(11'h7FF, 1'b1, 4'd8, 64'hDEAD_BEEF_0123_4567, 15'd0, -1, -1, -1, -1);
    checkOutput("remote_rtr_literal", 64'(rx_rtr), 64'd1);
    checkOutput("remote_data_literal", rx_data, 64'd0);

    runFrame(11'h055, 1'b0, 4'd1, 64'h3C00_0000_0000_0000, 15'd0, -1, 22, -1, -1);
    integrate(11, -1);

    runFrame(11'h2F0, 1'b0, 4'd1, 64'h8100_0000_0000_0000, 15'd0,
             eofStart(1'b0, 4'd1) + 2, -1, -1, -1);
    integrate(11, -1);

    runFrame(11'h2A6, 1'b0, 4'd12, 64'h0123_4567_89AB_CDEF, 15'd0, -1, -1, 5, -1);
    checkOutput("dlc12_data_literal", rx_data, 64'h0123_4567_89AB_CDEF);

    runFrame(11'h1C3, 1'b0, 4'd12, 64'hFEDC_BA98_7654_3210, 15'd0, -1, -1, -1, 39);
    integrate(11, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
